mux_sel_scanner: RTL and testbench

Sequential select-line driver and sample collector for the 4:1 gate-level channel mux. It steps the mux selects S1:S0 through channels 0..3 and holds each channel for a programmable dwell time. At the end of each dwell it captures the mux output Q, then presents the four captured bits as one frame on a valid/ready handshake. It sits directly upstream of the mux select inputs and directly downstream of the mux output.

---
 rtl/mux_sel_scanner.sv | 136 +++++++++++++
 tb/tb_mux_sel_scanner.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_sel_scanner.sv
// mux_sel_scanner
//
// Steps the select lines of a 4:1 channel mux through channels 0..3, holding
// each channel for DWELL cycles, and samples the mux output Q at the end of
// each dwell. The four samples are then offered as one frame on a
// valid/ready handshake.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   start        begin a scan (honoured only in IDLE)
//   cont         continuous mode, sampled on the frame handshake edge
//   Q            mux output
//   S0, S1       mux select lines
//   frame        captured frame, frame[n] = Q while channel n was selected
//   frame_valid  frame offered downstream
//   frame_ready  downstream accepts the frame
//   busy         high outside IDLE
//   frame_cnt    accepted frame count, wraps at 256
module mux_sel_scanner #(
  parameter int unsigned DWELL = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cont,
  input  logic       Q,
  output logic       S0,
  output logic       S1,
  output logic [3:0] frame,
  output logic       frame_valid,
  input  logic       frame_ready,
  output logic       busy,
  output logic [7:0] frame_cnt
);

  localparam logic [3:0] DwellLast = 4'(DWELL - 1);

  typedef enum logic [1:0] {StIdle, StScan, StPresent} state_e;

  state_e     state_q, state_d;
  logic [1:0] ch_q, ch_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] sh_q, sh_d;
  logic [3:0] frame_q, frame_d;
  logic       frame_valid_q, frame_valid_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    state_d       = state_q;
    ch_d          = ch_q;
    cnt_d         = cnt_q;
    sh_d          = sh_q;
    frame_d       = frame_q;
    frame_valid_d = frame_valid_q;
    frame_cnt_d   = frame_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StScan;
          ch_d    = 2'd0;
          cnt_d   = 4'd0;
          sh_d    = 4'd0;
        end
      end
      StScan: begin
        if (cnt_q == DwellLast) begin
          sh_d[ch_q] = Q;
          cnt_d      = 4'd0;
          if (ch_q != 2'd3) begin
            ch_d = ch_q + 2'd1;
          end else begin
            // Last sample goes straight into the frame; sh only holds ch 0..2 yet.
            frame_d       = {Q, sh_q[2:0]};
            frame_valid_d = 1'b1;
            state_d       = StPresent;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StPresent: begin
        if (frame_valid_q && frame_ready) begin
          frame_cnt_d   = frame_cnt_q + 8'd1;
          frame_valid_d = 1'b0;
          if (cont) begin
            state_d = StScan;
            ch_d    = 2'd0;
            cnt_d   = 4'd0;
            sh_d    = 4'd0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      ch_q          <= 2'd0;
      cnt_q         <= 4'd0;
      sh_q          <= 4'd0;
      frame_q       <= 4'd0;
      frame_valid_q <= 1'b0;
      frame_cnt_q   <= 8'd0;
    end else begin
      state_q       <= state_d;
      ch_q          <= ch_d;
      cnt_q         <= cnt_d;
      sh_q          <= sh_d;
      frame_q       <= frame_d;
      frame_valid_q <= frame_valid_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  // Selects follow ch only while scanning; IDLE and PRESENT park on channel 0.
  always_comb begin
    S0 = 1'b0;
    S1 = 1'b0;
    if (state_q == StScan) begin
      S0 = ch_q[0];
      S1 = ch_q[1];
    end
  end

  assign busy        = (state_q != StIdle);
  assign frame       = frame_q;
  assign frame_valid = frame_valid_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_mux_sel_scanner.sv
module tb_mux_sel_scanner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic cont = 1'b0;
  logic frame_ready = 1'b0;
  logic [3:0] data = 4'b0000;  // data[n] is mux input Dn

  // Instance a: DWELL = 2
  logic q_a, s0_a, s1_a, fv_a, busy_a;
  logic [3:0] frame_a;
  logic [7:0] fcnt_a;
  // Instance b: DWELL = 1
  logic q_b, s0_b, s1_b, fv_b, busy_b;
  logic [3:0] frame_b;
  logic [7:0] fcnt_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Behavioural 4:1 mux in front of each scanner.
  assign q_a = data[{s1_a, s0_a}];
  assign q_b = data[{s1_b, s0_b}];

  mux_sel_scanner #(.DWELL(2)) u_a (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .Q(q_a), .S0(s0_a), .S1(s1_a),
    .frame(frame_a), .frame_valid(fv_a), .frame_ready(frame_ready), .busy(busy_a),
    .frame_cnt(fcnt_a)
  );

  mux_sel_scanner #(.DWELL(1)) u_b (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .Q(q_b), .S0(s0_b), .S1(s1_b),
    .frame(frame_b), .frame_valid(fv_b), .frame_ready(frame_ready), .busy(busy_b),
    .frame_cnt(fcnt_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    start = 1'b0;
    repeat (2) step();
    rst = 1'b0;
  endtask

  // start is sampled at the next edge (E0); returns 1 time unit after E0.
  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++;
    if ({s1_a, s0_a, fv_a, busy_a, frame_a, fcnt_a} !== 16'h0) begin
      n_err++;
      $display("FAIL reset_a: got sel=%b%b fv=%b busy=%b frame=%b cnt=%0d want all zero",
               s1_a, s0_a, fv_a, busy_a, frame_a, fcnt_a);
    end
    n_cmp++;
    if ({s1_b, s0_b, fv_b, busy_b, frame_b, fcnt_b} !== 16'h0) begin
      n_err++;
      $display("FAIL reset_b: got sel=%b%b fv=%b busy=%b frame=%b cnt=%0d want all zero",
               s1_b, s0_b, fv_b, busy_b, frame_b, fcnt_b);
    end
  endtask

  task automatic test_single_scan();
    apply_reset();
    data = 4'b1011;
    cont = 1'b0;
    frame_ready = 1'b1;
    pulse_start();
    for (int k = 0; k < 8; k++) begin
      if (k > 0) step();
      n_cmp++;
      if ({s1_a, s0_a, busy_a, fv_a} !== {2'(k >> 1), 1'b1, 1'b0}) begin
        n_err++;
        $display("FAIL single_sel k=%0d: got sel=%b%b busy=%b fv=%b want sel=%0d busy=1 fv=0",
                 k, s1_a, s0_a, busy_a, fv_a, k >> 1);
      end
    end
    step();  // E0+8
    n_cmp++;
    if ({fv_a, frame_a, s1_a, s0_a} !== {1'b1, 4'b1011, 2'b00}) begin
      n_err++;
      $display("FAIL single_frame: got fv=%b frame=%b sel=%b%b want fv=1 frame=1011 sel=00",
               fv_a, frame_a, s1_a, s0_a);
    end
    step();  // E0+9
    n_cmp++;
    if ({busy_a, fv_a, frame_a, fcnt_a} !== {1'b0, 1'b0, 4'b1011, 8'd1}) begin
      n_err++;
      $display("FAIL single_done: got busy=%b fv=%b frame=%b cnt=%0d want 0 0 1011 1",
               busy_a, fv_a, frame_a, fcnt_a);
    end
  endtask

  task automatic test_continuous();
    apply_reset();
    data = 4'b0110;
    cont = 1'b1;
    frame_ready = 1'b1;
    pulse_start();
    for (int k = 1; k <= 15; k++) begin
      step();
      n_cmp++;
      if ({fv_b, fcnt_b} !== {1'((k % 5) == 4), 8'(k / 5)}) begin
        n_err++;
        $display("FAIL cont_timing k=%0d: got fv=%b cnt=%0d want fv=%0d cnt=%0d",
                 k, fv_b, fcnt_b, (k % 5) == 4, k / 5);
      end
      n_cmp++;
      if ({s1_b, s0_b} !== (((k % 5) == 4) ? 2'd0 : 2'(k % 5))) begin
        n_err++;
        $display("FAIL cont_sel k=%0d: got sel=%b%b", k, s1_b, s0_b);
      end
      if ((k % 5) == 4) begin
        n_cmp++;
        if (frame_b !== 4'b0110) begin
          n_err++;
          $display("FAIL cont_frame k=%0d: got %b want 0110", k, frame_b);
        end
      end
    end
    cont = 1'b0;
  endtask

  task automatic test_back_pressure();
    apply_reset();
    data = 4'b1001;
    cont = 1'b0;
    frame_ready = 1'b0;
    pulse_start();
    repeat (8) step();  // E0+8: frame presented
    for (int k = 0; k < 10; k++) begin
      if (k > 0) step();
      n_cmp++;
      if ({fv_a, frame_a, s1_a, s0_a, busy_a, fcnt_a} !==
          {1'b1, 4'b1001, 2'b00, 1'b1, 8'd0}) begin
        n_err++;
        $display("FAIL bp_hold k=%0d: got fv=%b frame=%b sel=%b%b busy=%b cnt=%0d",
                 k, fv_a, frame_a, s1_a, s0_a, busy_a, fcnt_a);
      end
    end
    frame_ready = 1'b1;
    step();
    frame_ready = 1'b0;
    n_cmp++;
    if ({fv_a, busy_a, fcnt_a} !== {1'b0, 1'b0, 8'd1}) begin
      n_err++;
      $display("FAIL bp_accept: got fv=%b busy=%b cnt=%0d want 0 0 1", fv_a, busy_a, fcnt_a);
    end
    frame_ready = 1'b1;
    step();
    frame_ready = 1'b0;
    n_cmp++;
    if ({fcnt_a, frame_a} !== {8'd1, 4'b1001}) begin
      n_err++;
      $display("FAIL bp_single: got cnt=%0d frame=%b want 1 1001", fcnt_a, frame_a);
    end
  endtask

  task automatic test_start_ignored();
    apply_reset();
    data = 4'b0101;
    cont = 1'b0;
    frame_ready = 1'b1;
    pulse_start();       // E0
    repeat (3) step();   // E0+3
    start = 1'b1;        // sampled in SCAN at E0+4
    step();
    start = 1'b0;
    n_cmp++;
    if ({s1_a, s0_a, busy_a} !== {2'd2, 1'b1}) begin
      n_err++;
      $display("FAIL ign_scan: got sel=%b%b busy=%b want 10 1", s1_a, s0_a, busy_a);
    end
    repeat (4) step();   // E0+8
    n_cmp++;
    if ({fv_a, frame_a} !== {1'b1, 4'b0101}) begin
      n_err++;
      $display("FAIL ign_frame: got fv=%b frame=%b want 1 0101", fv_a, frame_a);
    end
    start = 1'b1;        // sampled in PRESENT at E0+9
    step();
    start = 1'b0;
    n_cmp++;
    if ({busy_a, fv_a, fcnt_a} !== {1'b0, 1'b0, 8'd1}) begin
      n_err++;
      $display("FAIL ign_present: got busy=%b fv=%b cnt=%0d want 0 0 1", busy_a, fv_a, fcnt_a);
    end
    step();
    n_cmp++;
    if (busy_a !== 1'b0) begin
      n_err++;
      $display("FAIL ign_queue: got busy=%b want 0", busy_a);
    end
  endtask

  task automatic test_reset_mid_scan();
    apply_reset();
    data = 4'b1111;
    cont = 1'b0;
    frame_ready = 1'b1;
    pulse_start();
    repeat (2) step();
    rst = 1'b1;
    step();
    n_cmp++;
    if ({busy_a, s1_a, s0_a, fv_a, frame_a, fcnt_a} !== 16'h0) begin
      n_err++;
      $display("FAIL rst_mid: got busy=%b sel=%b%b fv=%b frame=%b cnt=%0d want all zero",
               busy_a, s1_a, s0_a, fv_a, frame_a, fcnt_a);
    end
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      n_cmp++;
      if ({fv_a, busy_a, fcnt_a} !== {1'b0, 1'b0, 8'd0}) begin
        n_err++;
        $display("FAIL rst_after k=%0d: got fv=%b busy=%b cnt=%0d", k, fv_a, busy_a, fcnt_a);
      end
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    data = 4'b1100;
    cont = 1'b1;
    frame_ready = 1'b1;
    pulse_start();
    repeat (1275) step();
    n_cmp++;
    if ({fcnt_b, fv_b} !== {8'd255, 1'b0}) begin
      n_err++;
      $display("FAIL wrap_255: got cnt=%0d fv=%b want 255 0", fcnt_b, fv_b);
    end
    repeat (4) step();
    n_cmp++;
    if ({fv_b, frame_b} !== {1'b1, 4'b1100}) begin
      n_err++;
      $display("FAIL wrap_frame: got fv=%b frame=%b want 1 1100", fv_b, frame_b);
    end
    step();
    n_cmp++;
    if ({fcnt_b, busy_b, fv_b} !== {8'd0, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL wrap_zero: got cnt=%0d busy=%b fv=%b want 0 1 0", fcnt_b, busy_b, fv_b);
    end
    cont = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_scan();
    test_continuous();
    test_back_pressure();
    test_start_ignored();
    test_reset_mid_scan();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
